mem_arbiter: RTL and testbench

Single-port arbiter between the instruction and data caches and the unified RAM. It takes the cache-side request bus (instruction read, data read/write), grants one request at a time to the RAM, and returns wait/load responses to each cache. The data side has priority, and a bounded-starvation counter guarantees instruction fetch progress. It sits directly downstream of the cache wrapper and upstream of the RAM model.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side memory types: RAM status encoding and the 32-bit word.
// No logic and no latency; the type definitions carry no flow control.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/RAM request bus around the arbiter: master = arbiter, slave = caches plus RAM.
// Pure wiring; the caches hold their requests until their wait drops, and the RAM paces grants with ramstate.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    word_t     iload;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter, data-priority with bounded instruction starvation; 2-cycle min latency.
// Each RAM BUSY/ERROR cycle holds the grant one more cycle; withdrawn requests release the RAM without a response.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.master bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DGRANT = 2'd1;
    localparam logic [1:0] IGRANT = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          dreq;
    logic          access;
    logic          forced;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        dreq   = bus.dREN | bus.dWEN;
        access = (bus.ramstate == ACCESS);
        // The pending fetch has watched STARVE_MAX data grants go by; it wins this arbitration.
        forced = (starve_cnt == SMAX) && bus.iREN;

        state_nxt    = state;
        starve_nxt   = starve_cnt;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;

        case (state)
            IDLE: begin
                if (!bus.iREN) begin
                    starve_nxt = '0;
                end
                if (dreq && !forced) begin
                    state_nxt = DGRANT;
                end else if (bus.iREN) begin
                    state_nxt = IGRANT;
                end
            end

            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (access) begin
                    bus.dload = bus.ramload;
                end
                if (!dreq) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    bus.dwait = 1'b0;
                    state_nxt = IDLE;
                    if (bus.iREN && (starve_cnt != SMAX)) begin
                        starve_nxt = starve_cnt + CW'(1);
                    end
                end
            end

            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (access) begin
                    bus.iload = bus.ramload;
                end
                if (!bus.iREN) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    bus.iwait  = 1'b0;
                    state_nxt  = IDLE;
                    starve_nxt = '0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scripted RAM latency model, a transaction-level ownership model
// checked every negedge, and hand-computed literal expectations per scenario.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_MAX = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endfunction

    // RAM model: BUSY for lat grant cycles, then ACCESS; optional ERROR on grant cycle err_cycle.
    int    lat       = 0;
    int    err_cycle = -1;
    int    ram_cnt   = 0;
    word_t rd_word   = '0;
    logic  strobe;

    assign strobe       = bus.ramREN | bus.ramWEN;
    assign bus.ramload  = rd_word;
    assign bus.ramstate = !strobe                ? FREE  :
                          (ram_cnt == err_cycle) ? ERROR :
                          (ram_cnt >= lat)       ? ACCESS : BUSY;

    always @(posedge CLK) begin
        ram_cnt <= (strobe && bus.ramstate != ACCESS) ? ram_cnt + 1 : 0;
    end

    // Reference model: who owns the RAM (0 none, 1 data, 2 instr) and how many data
    // completions the waiting fetch has already conceded.
    int own     = 0;
    int dstreak = 0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            own     = 0;
            dstreak = 0;
        end else begin
            logic dq, acc;
            dq  = bus.dREN | bus.dWEN;
            acc = (bus.ramstate == ACCESS);
            if (own == 0) begin
                if (!bus.iREN) dstreak = 0;
                if (bus.iREN && dstreak >= STARVE_MAX) own = 2;
                else if (dq)                         own = 1;
                else if (bus.iREN)                   own = 2;
            end else if (own == 1) begin
                if (!dq) own = 0;
                else if (acc) begin
                    own = 0;
                    if (bus.iREN) dstreak = (dstreak < STARVE_MAX) ? dstreak + 1 : STARVE_MAX;
                end
            end else begin
                if (!bus.iREN) own = 0;
                else if (acc) begin
                    own     = 0;
                    dstreak = 0;
                end
            end
        end
    end

    byte  log_q[$];
    int   dpulses    = 0;
    int   ipulses    = 0;
    int   ren_cycles = 0;
    logic prev_pulse = 1'b0;

    always @(negedge CLK) begin : cmp
        logic  acc, dq, e_ren, e_wen, e_iwait, e_dwait, pulse;
        word_t e_addr, e_store, e_iload, e_dload;
        acc = (bus.ramstate == ACCESS);
        dq  = bus.dREN | bus.dWEN;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
        if (own == 1) begin
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN && !bus.dWEN;
            e_dwait = !(dq && acc);
            e_dload = acc ? bus.ramload : 0;
        end else if (own == 2) begin
            e_addr  = bus.iaddr;
            e_ren   = bus.iREN;
            e_iwait = !(bus.iREN && acc);
            e_iload = acc ? bus.ramload : 0;
        end
        check("ramREN",   bus.ramREN,   e_ren);
        check("ramWEN",   bus.ramWEN,   e_wen);
        check("ramaddr",  bus.ramaddr,  e_addr);
        check("ramstore", bus.ramstore, e_store);
        check("iwait",    bus.iwait,    e_iwait);
        check("dwait",    bus.dwait,    e_dwait);
        check("iload",    bus.iload,    e_iload);
        check("dload",    bus.dload,    e_dload);
        if (nRST) begin
            check("wait_exclusive", !bus.iwait && !bus.dwait, 0);
            pulse = !bus.iwait || !bus.dwait;
            if (pulse) check("wait_gap", prev_pulse, 0);
            prev_pulse = pulse;
            if (!bus.dwait) begin log_q.push_back(8'h44); dpulses++; end
            if (!bus.iwait) begin log_q.push_back(8'h49); ipulses++; end
            if (bus.ramREN) ren_cycles++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input bit want_d, output int cycles, output word_t word, output word_t addr);
        cycles = 0;
        word   = '0;
        addr   = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            cycles++;
            if (want_d ? !bus.dwait : !bus.iwait) begin
                word = want_d ? bus.dload : bus.iload;
                addr = bus.ramaddr;
                return;
            end
        end
        n_chk++;
        $display("FAIL %s_timeout: no wait pulse within 60 cycles, required one", want_d ? "dwait" : "iwait");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int    cyc, r0, p0;
        word_t w, a;
        byte   exp_seq [0:5];
        exp_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};

        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0;
        rd_word = 32'hFFFF_FFFF;

        // Reset values
        #1 nRST = 1'b0;
        #2;
        check("rst_ramREN",   bus.ramREN,   0);
        check("rst_ramWEN",   bus.ramWEN,   0);
        check("rst_ramaddr",  bus.ramaddr,  0);
        check("rst_ramstore", bus.ramstore, 0);
        check("rst_iwait",    bus.iwait,    1);
        check("rst_dwait",    bus.dwait,    1);
        check("rst_iload",    bus.iload,    0);
        check("rst_dload",    bus.dload,    0);
        repeat (2) @(negedge CLK);
        #1 nRST = 1'b1;
        tick();

        // Data read alone, two BUSY cycles
        lat = 2; rd_word = 32'hDEAD_BEEF;
        r0 = ren_cycles; p0 = ipulses;
        bus.daddr = 32'h40; bus.dREN = 1;
        wait_done(1, cyc, w, a);
        tick(); bus.dREN = 0;
        check("rd_latency", cyc, 4);
        check("rd_dload",   w,   32'hDEAD_BEEF);
        check("rd_addr",    a,   32'h40);
        check("rd_ren_cycles", ren_cycles - r0, 3);
        check("rd_no_iwait",   ipulses - p0,    0);
        tick();

        // Simultaneous requests: data first, then instruction after one idle cycle
        lat = 0; rd_word = 32'hCAFE_0001;
        bus.iaddr = 32'h100; bus.daddr = 32'h80;
        bus.iREN = 1; bus.dREN = 1;
        wait_done(1, cyc, w, a);
        check("sim_d_latency", cyc, 2);
        check("sim_d_addr",    a,   32'h80);
        tick(); bus.dREN = 0;
        wait_done(0, cyc, w, a);
        check("sim_i_latency", cyc, 2);
        check("sim_i_addr",    a,   32'h100);
        check("sim_i_iload",   w,   32'hCAFE_0001);
        tick(); bus.iREN = 0;
        tick();

        // Starvation bound: both held high continuously
        lat = 1; log_q.delete();
        bus.iaddr = 32'h104; bus.daddr = 32'h84;
        bus.iREN = 1; bus.dREN = 1;
        for (int k = 0; k < 200 && log_q.size() < 6; k++) @(negedge CLK);
        tick(); bus.iREN = 0; bus.dREN = 0;
        check("starve_count", log_q.size() >= 6, 1);
        for (int k = 0; k < 6; k++) begin
            byte got;
            got = (k < log_q.size()) ? log_q[k] : 8'h00;
            check($sformatf("starve_seq%0d", k), got, exp_seq[k]);
        end
        tick();

        // Write: dWEN dominates dREN
        lat = 1; p0 = dpulses;
        bus.daddr = 32'h200; bus.dstore = 32'h1234_5678;
        bus.dWEN = 1; bus.dREN = 1;
        wait_done(1, cyc, w, a);
        check("wr_ramWEN",   bus.ramWEN,   1);
        check("wr_ramREN",   bus.ramREN,   0);
        check("wr_ramstore", bus.ramstore, 32'h1234_5678);
        check("wr_latency",  cyc,          3);
        tick(); bus.dWEN = 0; bus.dREN = 0; bus.dstore = 0;
        repeat (3) tick();
        check("wr_one_pulse", dpulses - p0, 1);

        // ERROR then ACCESS during an instruction grant
        lat = 2; err_cycle = 1; rd_word = 32'h0BAD_F00D; p0 = ipulses;
        bus.iaddr = 32'h300; bus.iREN = 1;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("err_iwait",   bus.iwait,   1);
        check("err_ramREN",  bus.ramREN,  1);
        check("err_ramaddr", bus.ramaddr, 32'h300);
        @(negedge CLK);
        check("err_acc_iwait", bus.iwait, 0);
        check("err_acc_iload", bus.iload, 32'h0BAD_F00D);
        tick(); bus.iREN = 0; err_cycle = -1;
        tick();
        check("err_one_pulse", ipulses - p0, 1);

        // Reset during a BUSY data grant, then re-arbitration of the held request
        lat = 5; rd_word = 32'h5555_AAAA;
        bus.daddr = 32'h44; bus.dREN = 1;
        @(posedge CLK);
        #2;
        check("pre_rst_ramREN", bus.ramREN, 1);
        nRST = 1'b0;
        #1;
        check("mid_rst_ramREN",   bus.ramREN,   0);
        check("mid_rst_ramWEN",   bus.ramWEN,   0);
        check("mid_rst_ramaddr",  bus.ramaddr,  0);
        check("mid_rst_ramstore", bus.ramstore, 0);
        check("mid_rst_dwait",    bus.dwait,    1);
        check("mid_rst_dload",    bus.dload,    0);
        @(negedge CLK);
        #1 nRST = 1'b1;
        wait_done(1, cyc, w, a);
        check("post_rst_latency", cyc, 6);
        check("post_rst_addr",    a,   32'h44);
        check("post_rst_dload",   w,   32'h5555_AAAA);
        tick(); bus.dREN = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
